// File: rtl/clint_timer_master.sv
// Bus initiator that keeps one hart's MTIMECMP armed: reads MTIME, writes MTIMECMP
// with hi=max/lo/hi ordering, and re-arms drift-free on every mtip.
//  state    | meaning
//  IDLE     | parked; waits for en with err clear
//  RD_HI    | read MTIME hi (h1)
//  RD_LO    | read MTIME lo
//  RD_HI2   | re-read MTIME hi; retry lo if it moved
//  WR_HMAX  | park MTIMECMP hi at all-ones
//  WR_LO    | write compare lo
//  WR_HI    | write compare hi
//  SETTLE   | ignore mtip while the CLINT output settles
//  WAIT_IRQ | armed; waits for mtip
module clint_timer_master #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int HART       = 0,
    parameter int MTIME_BASE = 49144,
    parameter int TIMEOUT    = 255,
    parameter int SETTLE     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [31:0]         period,
    input  logic                mtip,
    output logic                valid,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                ready,
    output logic                tick,
    output logic                busy,
    output logic                err
);

    localparam int CMP_W = 2 * DATA_W;
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    localparam logic [ADDR_W-1:0] A_MT_LO  = ADDR_W'(MTIME_BASE);
    localparam logic [ADDR_W-1:0] A_MT_HI  = ADDR_W'(MTIME_BASE + 4);
    localparam logic [ADDR_W-1:0] A_CMP_LO = ADDR_W'(16384 + 8 * HART);
    localparam logic [ADDR_W-1:0] A_CMP_HI = ADDR_W'(16384 + 8 * HART + 4);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_HI    = 4'd1,
        RD_LO    = 4'd2,
        RD_HI2   = 4'd3,
        WR_HMAX  = 4'd4,
        WR_LO    = 4'd5,
        WR_HI    = 4'd6,
        SETTLE_S = 4'd7,
        WAIT_IRQ = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_nxt;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [TMO_W-1:0]    r_tmo;
    logic [SET_W-1:0]    r_settle;
    logic [31:0]         r_per;
    logic [CMP_W-1:0]    r_cmp;
    logic [DATA_W-1:0]   r_h1;
    logic [DATA_W-1:0]   r_lo;
    logic                r_err;

    logic                w_is_acc;
    logic                w_done;
    logic                w_tmo;
    logic                w_issue;
    logic                w_hi_moved;
    logic                w_rearm;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_wr;

    assign w_is_acc   = (r_state == RD_HI) || (r_state == RD_LO) || (r_state == RD_HI2) ||
                        (r_state == WR_HMAX) || (r_state == WR_LO) || (r_state == WR_HI);
    assign w_done     = w_is_acc && ready;
    assign w_tmo      = w_is_acc && !ready && (r_tmo == '0);
    assign w_hi_moved = (rdata != r_h1);
    assign w_rearm    = (r_state == WAIT_IRQ) && en && mtip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:     if (en && !r_err) w_nxt = RD_HI;
            RD_HI:    if (ready) w_nxt = RD_LO;
            RD_LO:    if (ready) w_nxt = RD_HI2;
            RD_HI2:   if (ready) w_nxt = w_hi_moved ? RD_LO : WR_HMAX;
            WR_HMAX:  if (ready) w_nxt = WR_LO;
            WR_LO:    if (ready) w_nxt = WR_HI;
            WR_HI:    if (ready) w_nxt = SETTLE_S;
            SETTLE_S: begin
                if (!en)                           w_nxt = IDLE;
                else if (r_settle <= SET_W'(1))    w_nxt = WAIT_IRQ;
            end
            WAIT_IRQ: begin
                if (!en)       w_nxt = IDLE;
                else if (mtip) w_nxt = WR_HMAX;
            end
            default:  w_nxt = IDLE;
        endcase
        // a disable never aborts a bus access; it takes effect once the access completes
        if (w_done && !en) w_nxt = IDLE;
        if (w_tmo)         w_nxt = IDLE;
    end

    always_comb begin
        busy = (r_state != IDLE) && (r_state != WAIT_IRQ);
        tick = w_rearm;
    end

    assign w_issue = (w_nxt != r_state) &&
                     ((w_nxt == RD_HI) || (w_nxt == RD_LO) || (w_nxt == RD_HI2) ||
                      (w_nxt == WR_HMAX) || (w_nxt == WR_LO) || (w_nxt == WR_HI));

    always_comb begin
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_wr    = 1'b0;
        case (w_nxt)
            RD_HI, RD_HI2: w_addr = A_MT_HI;
            RD_LO:         w_addr = A_MT_LO;
            WR_HMAX: begin
                w_addr  = A_CMP_HI;
                w_wdata = '1;
                w_wr    = 1'b1;
            end
            WR_LO: begin
                w_addr  = A_CMP_LO;
                w_wdata = r_cmp[DATA_W-1:0];
                w_wr    = 1'b1;
            end
            WR_HI: begin
                w_addr  = A_CMP_HI;
                w_wdata = r_cmp[CMP_W-1:DATA_W];
                w_wr    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_tmo   <= '0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_wstrb <= w_wr ? '1 : '0;
                r_tmo   <= TMO_W'(TIMEOUT - 1);
            end else begin
                if (w_done) r_wstrb <= '0;
                if (w_is_acc && !ready && (r_tmo != '0)) r_tmo <= r_tmo - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_per    <= '0;
            r_cmp    <= '0;
            r_h1     <= '0;
            r_lo     <= '0;
            r_settle <= '0;
            r_err    <= 1'b0;
        end else begin
            if ((r_state == IDLE) && en && !r_err) r_per <= period;
            if (w_rearm) begin
                r_per <= period;
                r_cmp <= r_cmp + CMP_W'(r_per);
            end
            if ((r_state == RD_HI) && ready) r_h1 <= rdata;
            if ((r_state == RD_LO) && ready) r_lo <= rdata;
            if ((r_state == RD_HI2) && ready) begin
                if (w_hi_moved) r_h1  <= rdata;
                else            r_cmp <= {r_h1, r_lo} + CMP_W'(r_per);
            end
            if ((r_state == WR_HI) && ready)                 r_settle <= SET_W'(SETTLE);
            else if ((r_state == SETTLE_S) && (r_settle != '0)) r_settle <= r_settle - 1'b1;
            if (w_tmo)                           r_err <= 1'b1;
            else if ((r_state == IDLE) && !en)   r_err <= 1'b0;
        end
    end

    assign valid   = r_valid;
    assign address = r_addr;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign err     = r_err;

endmodule

// File: tb/tb_clint_timer_master.sv
// Directed bench for clint_timer_master: a small CLINT responder (MTIME, MTIMECMP, mtip)
// with programmable ready latency, plus hand-computed expected bus traffic.
module tb_clint_timer_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] period;
    logic        mtip;
    logic        valid;
    logic [15:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        tick;
    logic        busy;
    logic        err;

    clint_timer_master dut (
        .clk(clk), .reset(reset), .en(en), .period(period), .mtip(mtip),
        .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .tick(tick), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // responder / CLINT model
    logic [63:0] mtime;
    logic [63:0] mt_eff;
    logic [63:0] mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        roll_arm;
    logic        roll_done = 1'b0;
    int          dly;
    logic        never;
    int          cnt = 0;

    assign mt_eff = (roll_arm && roll_done) ? 64'h1_0000_0005 : mtime;
    assign mtip   = (mt_eff >= mtimecmp);
    assign rdata  = (address == 16'd49148) ? mt_eff[63:32] :
                    (address == 16'd49144) ? mt_eff[31:0] : 32'h0;
    assign ready  = never ? 1'b0 : ((dly == 0) ? valid : (cnt == 1));

    int          n_valid = 0;
    int          n_ready = 0;
    int          n_tick  = 0;
    logic [15:0] log_addr [512];
    logic [31:0] log_data [512];
    logic [3:0]  log_strb [512];

    always @(posedge clk) begin
        if (valid && (dly != 0) && !never) cnt <= dly;
        else if (cnt != 0)                 cnt <= cnt - 1;
        if (!roll_arm) roll_done <= 1'b0;
        else if (ready && wstrb == 4'h0 && address == 16'd49148) roll_done <= 1'b1;
        if (ready && wstrb == 4'hF) begin
            if (address == 16'd16384) mtimecmp[31:0]  <= wdata;
            if (address == 16'd16388) mtimecmp[63:32] <= wdata;
        end
        if (valid) begin
            if (n_valid < 512) begin
                log_addr[n_valid] <= address;
                log_data[n_valid] <= wdata;
                log_strb[n_valid] <= wstrb;
            end
            n_valid <= n_valid + 1;
        end
        if (ready) n_ready <= n_ready + 1;
        if (tick)  n_tick  <= n_tick + 1;
    end

    int n_chk = 0;
    int n_err = 0;
    int base;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_armed(input int n, input int budget, input string tag);
        int k = 0;
        while (!(((n_valid - base) >= n) && !busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(((n_valid - base) >= n) && !busy), 64'd1);
    endtask

    task automatic go_idle();
        en = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic chk_acc(input string tag, input int idx, input logic [15:0] a,
                           input logic [3:0] s, input logic [31:0] d, input logic chk_d);
        chk({tag, "_addr"}, 64'(log_addr[base + idx]), 64'(a));
        chk({tag, "_strb"}, 64'(log_strb[base + idx]), 64'(s));
        if (chk_d) chk({tag, "_data"}, 64'(log_data[base + idx]), 64'(d));
    endtask

    initial begin
        int k, sv, st, sr;
        reset = 1'b1; en = 1'b0; period = 32'd0; mtime = 64'd100;
        roll_arm = 1'b0; dly = 0; never = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_err",   64'(err),   64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_tick", 64'(tick), 64'd0);
        chk("post_rst_addr", 64'(address), 64'd0);

        // basic arm: MTIME=100, period=20, zero-latency responder
        base = n_valid; period = 32'd20; en = 1'b1;
        wait_armed(6, 200, "t1_arm");
        chk_acc("t1_a0", 0, 16'd49148, 4'h0, 32'h0, 1'b0);
        chk_acc("t1_a1", 1, 16'd49144, 4'h0, 32'h0, 1'b0);
        chk_acc("t1_a2", 2, 16'd49148, 4'h0, 32'h0, 1'b0);
        chk_acc("t1_a3", 3, 16'd16388, 4'hF, 32'hFFFF_FFFF, 1'b1);
        chk_acc("t1_a4", 4, 16'd16384, 4'hF, 32'd120, 1'b1);
        chk_acc("t1_a5", 5, 16'd16388, 4'hF, 32'd0, 1'b1);
        chk("t1_cmp", mtimecmp, 64'd120);
        chk("t1_no_tick", 64'(n_tick), 64'd0);
        st = n_tick;
        mtime = 64'd120;
        wait_armed(9, 100, "t1_rearm");
        chk("t1_ticks", 64'(n_tick - st), 64'd1);
        chk_acc("t1_a6", 6, 16'd16388, 4'hF, 32'hFFFF_FFFF, 1'b1);
        chk_acc("t1_a7", 7, 16'd16384, 4'hF, 32'd140, 1'b1);
        chk_acc("t1_a8", 8, 16'd16388, 4'hF, 32'd0, 1'b1);
        chk("t1_cmp2", mtimecmp, 64'd140);

        // ready delayed by 7 cycles gives identical results
        go_idle();
        mtime = 64'd100; dly = 7;
        base = n_valid; sr = n_ready; en = 1'b1;
        wait_armed(6, 300, "t3_arm");
        chk("t3_nvalid", 64'(n_valid - base), 64'd6);
        chk("t3_nready", 64'(n_ready - sr), 64'd6);
        chk_acc("t3_a4", 4, 16'd16384, 4'hF, 32'd120, 1'b1);
        chk("t3_cmp", mtimecmp, 64'd120);
        chk("t3_strb_after", 64'(wstrb), 64'd0);

        // MTIME lo rolls over between the two hi reads
        go_idle();
        dly = 0; mtime = 64'h0_FFFF_FFF0; roll_arm = 1'b1;
        base = n_valid; en = 1'b1;
        wait_armed(8, 200, "t4_arm");
        chk("t4_nacc", 64'(n_valid - base), 64'd8);
        chk_acc("t4_a3", 3, 16'd49144, 4'h0, 32'h0, 1'b0);
        chk_acc("t4_a4", 4, 16'd49148, 4'h0, 32'h0, 1'b0);
        chk_acc("t4_a6", 6, 16'd16384, 4'hF, 32'h19, 1'b1);
        chk_acc("t4_a7", 7, 16'd16388, 4'hF, 32'h1, 1'b1);
        chk("t4_cmp", mtimecmp, 64'h1_0000_0019);
        go_idle();
        roll_arm = 1'b0;

        // responder never answers: timeout at cycle 255 after valid
        never = 1'b1; base = n_valid; en = 1'b1;
        k = 0;
        while (!valid && k < 20) begin @(negedge clk); k++; end
        chk("t5_valid_seen", 64'(valid), 64'd1);
        k = 0;
        while (!err && k < 400) begin @(negedge clk); k++; end
        chk("t5_err_cycle", 64'(k), 64'd255);
        chk("t5_busy", 64'(busy), 64'd0);
        repeat (10) @(negedge clk);
        chk("t5_no_retry", 64'(n_valid - base), 64'd1);
        chk("t5_err_sticky", 64'(err), 64'd1);
        en = 1'b0;
        @(negedge clk);
        chk("t5_err_clear", 64'(err), 64'd0);
        never = 1'b0;
        repeat (3) @(negedge clk);

        // period=0: mtip stays high, one tick per re-arm loop
        mtime = 64'd500; period = 32'd0; base = n_valid; en = 1'b1;
        k = 0;
        while (!tick && k < 100) begin @(negedge clk); k++; end
        chk("t6_first_tick", 64'(tick), 64'd1);
        k = 0;
        do begin @(negedge clk); k++; end while (!tick && k < 50);
        chk("t6_spacing", 64'(k), 64'd8);
        chk("t6_cmp", mtimecmp, 64'd500);
        en = 1'b0; st = n_tick;
        repeat (12) @(negedge clk);
        sv = n_valid;
        repeat (20) @(negedge clk);
        chk("t6_no_valid", 64'(n_valid - sv), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_no_tick", 64'(n_tick - st), 64'd0);

        // async reset during WR_LO, then full restart
        mtime = 64'd100; period = 32'd20; dly = 3; en = 1'b1;
        k = 0;
        while (!(valid && address == 16'd16384) && k < 300) begin @(negedge clk); k++; end
        chk("t7_reach_wrlo", 64'(valid && address == 16'd16384), 64'd1);
        reset = 1'b1;
        #1;
        chk("t7_valid0", 64'(valid), 64'd0);
        chk("t7_addr0",  64'(address), 64'd0);
        chk("t7_wdata0", 64'(wdata), 64'd0);
        chk("t7_wstrb0", 64'(wstrb), 64'd0);
        chk("t7_busy0",  64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        base = n_valid;
        reset = 1'b0;
        wait_armed(6, 300, "t7_rearm");
        chk_acc("t7_a0", 0, 16'd49148, 4'h0, 32'h0, 1'b0);
        chk_acc("t7_a1", 1, 16'd49144, 4'h0, 32'h0, 1'b0);
        chk_acc("t7_a2", 2, 16'd49148, 4'h0, 32'h0, 1'b0);
        chk_acc("t7_a4", 4, 16'd16384, 4'hF, 32'd120, 1'b1);
        chk("t7_cmp", mtimecmp, 64'd120);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
